alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high (clk, rst).
REQ-002 Parameter: FIFO_DEPTH, default 4, number of buffered commands (power of two, >=2).
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cmd_valid  in  1  command present; cmd_ready  out  1  command accepted when both high at a clk edge.
REQ-006 cmd_a, cmd_b  in  8 each  operands; cmd_op  in  3  opcode; cmd_tag  in  2  caller ID returned with the response.
REQ-007 alu_a, alu_b  out  8 each, alu_op  out  3  registered operands/opcode driven to the combinational ALU.
REQ-008 alu_result  in  8, alu_carry  in  1  combinational ALU outputs (ADD carry-out, SUB borrow, 0 for logic ops).
REQ-009 rsp_valid  out  1, rsp_ready  in  1  response handshake; transfer when both high at a clk edge.
REQ-010 rsp_result  out  8, rsp_carry  out  1, rsp_zero  out  1, rsp_err  out  1, rsp_tag  out  2  response fields.
REQ-011 busy  out  1  high when FSM is not IDLE or FIFO non-empty.

Function
REQ-012 Opcodes SHALL be 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; 101-111 invalid.
REQ-013 Commands SHALL be pushed into a FIFO_DEPTH-entry FIFO (a,b,op,tag); cmd_ready = FIFO not full, independent of same-cycle pop (no full-bypass).
REQ-014 FSM states SHALL be IDLE, ISSUE, RESP.
REQ-015 IDLE -> ISSUE when FIFO non-empty at the edge; on that edge head is popped into alu_a/alu_b/alu_op and tag register.
REQ-016 ISSUE -> RESP unconditionally after one cycle; on that edge alu_result/alu_carry are captured into rsp_result/rsp_carry, rsp_zero = (captured result == 0), rsp_valid set.
REQ-017 Invalid opcode: ALU still driven; captured rsp_result=0x00, rsp_carry=0, rsp_zero=1, rsp_err=1; valid opcodes give rsp_err=0.
REQ-018 RESP: all rsp_* held stable while rsp_valid && !rsp_ready.
REQ-019 RESP with rsp_ready: rsp_valid clears, -> ISSUE with pop if FIFO non-empty (back-to-back), else -> IDLE.
REQ-020 Latency: command accepted at edge N into idle, empty block -> rsp_valid high after edge N+2; peak throughput one response per 2 cycles.
REQ-021 Push into empty FIFO SHALL NOT be popped the same edge (no bypass); simultaneous push and pop on non-full FIFO SHALL keep count unchanged.
REQ-022 Responses SHALL return in command-acceptance order; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-023 alu_a/alu_b/alu_op SHALL hold their last issued values outside ISSUE.

Reset
REQ-024 rst at any edge SHALL force FSM=IDLE, FIFO empty (pointers and count 0), discarding buffered and in-flight commands.
REQ-025 Reset values: cmd_ready=0 during rst then 1 after, rsp_valid=0, rsp_result=0x00, rsp_carry=0, rsp_zero=0, rsp_err=0, rsp_tag=0, alu_a=alu_b=0x00, alu_op=000, busy=0.
REQ-026 rst asserted mid-RESP SHALL drop rsp_valid the following cycle without a handshake.

Structure
REQ-027 Shared package alu_pkg SHALL hold opcode constants, the FSM state type and the default FIFO_DEPTH.
REQ-028 The FIFO SHALL be a separate sub-module alu_cmd_fifo (sync, count-based full/empty); the ALU stays external.

Verification (bench connects alu_8bit to alu_* ports)
REQ-029 ADD A=0xFF,B=0x01 -> rsp_result=0x00, carry=1, zero=1, err=0, rsp_valid 2 cycles after accept.
REQ-030 SUB A=0x05,B=0x07 -> 0xFE, carry=1; XOR 0xAA,0x55 -> 0xFF, carry=0, zero=0.
REQ-031 op=110, A=0x12,B=0x34 -> result=0x00, carry=0, zero=1, err=1.
REQ-032 Push 5 commands tags 0,1,2,3,0 with rsp_ready=0 -> cmd_ready low after 4th buffered beyond in-flight; release rsp_ready -> tags return in order, one per 2 cycles.
REQ-033 rsp_ready toggled randomly -> rsp_* stable while stalled, no loss or duplication over 100 commands.
REQ-034 rst asserted in RESP with 2 queued -> next cycle rsp_valid=0, busy=0, cmd_ready=1, no further responses.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM state type,
// the buffered command record and the default queue depth.
package alu_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [1:0] tag;
    } cmd_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response channels of the sequencer. Both channels use
// valid/ready: a beat transfers on a rising clk edge where valid and ready are
// both high; a producer holds valid and its payload stable until that edge.
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [2:0] cmd_op;
    logic [1:0] cmd_tag;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_zero;
    logic       rsp_err;
    logic [1:0] rsp_tag;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        input  cmd_ready,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
        output cmd_ready,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err, rsp_tag,
        input  rsp_ready
    );

endinterface

// File: rtl/alu_8bit.sv
// Combinational 8-bit ALU driven by the sequencer. Carry is the ADD carry-out
// or the SUB borrow; undefined opcodes pass operand A through.
module alu_8bit
    import alu_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic [2:0] i_op,
    output logic [7:0] o_result,
    output logic       o_carry
);

    logic [8:0] w_wide;

    always_comb begin
        w_wide   = '0;
        o_result = i_a;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_wide   = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            OP_SUB: begin
                w_wide   = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_wide[7:0];
                o_carry  = w_wide[8];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = i_a;
        endcase
    end

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with count-based full/empty. A push into an empty
// FIFO only becomes visible at the head after the edge that stores it.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_push,
    input  cmd_t i_data,
    input  logic i_pop,
    output cmd_t o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    cmd_t             r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to an external ALU and
// returns tagged responses in acceptance order.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    alu_cmd_sequencer_if.slave        bus,
    output logic [7:0]                o_alu_a,
    output logic [7:0]                o_alu_b,
    output logic [2:0]                o_alu_op,
    input  logic [7:0]                i_alu_result,
    input  logic                      i_alu_carry,
    output logic                      o_busy,
    output seq_state_t                o_state
);

    seq_state_t r_state;
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic [1:0] r_tag;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_result;
    logic       r_rsp_carry;
    logic       r_rsp_zero;
    logic       r_rsp_err;
    logic [1:0] r_rsp_tag;

    cmd_t w_cmd_in;
    cmd_t w_head;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_op_ok;

    assign w_cmd_in      = '{a: bus.cmd_a, b: bus.cmd_b, op: bus.cmd_op, tag: bus.cmd_tag};
    assign bus.cmd_ready = !rst && !w_full;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    // Head is taken when idle, or right at the response handshake (back-to-back).
    assign w_pop         = !w_empty &&
                           ((r_state == ST_IDLE) || ((r_state == ST_RESP) && bus.rsp_ready));
    assign w_op_ok       = op_is_valid(r_alu_op);

    alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_cmd_in),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_tag        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_carry  <= 1'b0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_tag    <= '0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= w_head.a;
                r_alu_b  <= w_head.b;
                r_alu_op <= w_head.op;
                r_tag    <= w_head.tag;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) r_state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= w_op_ok ? i_alu_result : 8'h00;
                    r_rsp_carry  <= w_op_ok && i_alu_carry;
                    r_rsp_zero   <= !w_op_ok || (i_alu_result == 8'h00);
                    r_rsp_err    <= !w_op_ok;
                    r_rsp_tag    <= r_tag;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= w_pop ? ST_ISSUE : ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_carry  = r_rsp_carry;
    assign bus.rsp_zero   = r_rsp_zero;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_tag    = r_rsp_tag;

    assign o_alu_a  = r_alu_a;
    assign o_alu_b  = r_alu_b;
    assign o_alu_op = r_alu_op;
    assign o_busy   = (r_state != ST_IDLE) || !w_empty;
    assign o_state  = r_state;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with the alu_8bit ALU attached.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W = 13;  // {tag, err, zero, carry, result}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus();

    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_carry, busy;
    seq_state_t state;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .o_alu_a      (alu_a),
        .o_alu_b      (alu_b),
        .o_alu_op     (alu_op),
        .i_alu_result (alu_result),
        .i_alu_carry  (alu_carry),
        .o_busy       (busy),
        .o_state      (state)
    );

    alu_8bit u_alu (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_op     (alu_op),
        .o_result (alu_result),
        .o_carry  (alu_carry)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    // Reference: response a command should produce, from the opcode rules.
    function automatic logic [W-1:0] ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op, input logic [1:0] tag);
        int res;
        logic c, e;
        logic [7:0] r8;
        c = 1'b0;
        e = 1'b0;
        case (op)
            3'd0: begin res = int'(a) + int'(b); c = (res > 255); end
            3'd1: begin res = int'(a) - int'(b) + 256; c = (a < b); end
            3'd2: res = int'(a & b);
            3'd3: res = int'(a | b);
            3'd4: res = int'(a ^ b);
            default: begin res = 0; e = 1'b1; end
        endcase
        res = res % 256;
        r8 = res[7:0];
        return {tag, e, (r8 == 8'h00), c, r8};
    endfunction

    function automatic logic [W-1:0] obs_rsp();
        return {bus.rsp_tag, bus.rsp_err, bus.rsp_zero, bus.rsp_carry, bus.rsp_result};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_op = '0; bus.cmd_tag = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready_in_rst: got %b want 0", bus.cmd_ready); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++;
        if (obs_rsp() !== '0) begin n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", obs_rsp()); end
        n_checks++;
        if ({alu_a, alu_b, alu_op} !== '0) begin n_fail++; $display("FAIL reset_alu_regs: got %h %h %h want 0", alu_a, alu_b, alu_op); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++;
        if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready_after: got %b want 1", bus.cmd_ready); end
        n_checks++;
        if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", state, ST_IDLE); end
    endtask

    // Single commands into an idle block: literal expected results and latency.
    task automatic test_directed();
        logic [7:0] ta [4], tbv [4], er [4];
        logic [2:0] to [4];
        logic [1:0] tt [4];
        logic       ec [4], ez [4], ee [4];
        ta = '{8'hFF, 8'h05, 8'hAA, 8'h12};
        tbv = '{8'h01, 8'h07, 8'h55, 8'h34};
        to = '{3'b000, 3'b001, 3'b100, 3'b110};
        tt = '{2'd1, 2'd2, 2'd3, 2'd0};
        er = '{8'h00, 8'hFE, 8'hFF, 8'h00};
        ec = '{1'b1, 1'b1, 1'b0, 1'b0};
        ez = '{1'b1, 1'b0, 1'b0, 1'b1};
        ee = '{1'b0, 1'b0, 1'b0, 1'b1};
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.cmd_valid = 1'b1;
            bus.cmd_a = ta[i]; bus.cmd_b = tbv[i]; bus.cmd_op = to[i]; bus.cmd_tag = tt[i];
            @(negedge clk);
            n_checks++;
            if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL dir%0d_cmd_ready: got %b want 1", i, bus.cmd_ready); end
            @(posedge clk); #1 bus.cmd_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL dir%0d_after_accept valid/busy: got %b want 01", i, {bus.rsp_valid, busy}); end
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, alu_a, alu_b, alu_op} !== {1'b0, ta[i], tbv[i], to[i]}) begin
                n_fail++; $display("FAIL dir%0d_issue valid/a/b/op: got %b %h %h %h want 0 %h %h %h",
                                   i, bus.rsp_valid, alu_a, alu_b, alu_op, ta[i], tbv[i], to[i]);
            end
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL dir%0d_latency: rsp_valid got %b want 1", i, bus.rsp_valid); end
            n_checks++;
            if (obs_rsp() !== {tt[i], ee[i], ez[i], ec[i], er[i]}) begin
                n_fail++; $display("FAIL dir%0d_fields: got %h want %h", i, obs_rsp(), {tt[i], ee[i], ez[i], ec[i], er[i]});
            end
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, busy, alu_a, alu_op} !== {2'b00, ta[i], to[i]}) begin
                n_fail++; $display("FAIL dir%0d_idle_hold valid/busy/a/op: got %b%b %h %h want 00 %h %h",
                                   i, bus.rsp_valid, busy, alu_a, alu_op, ta[i], to[i]);
            end
        end
    endtask

    // Fill behind a stalled response, then drain in order at one per 2 cycles.
    task automatic test_fill_order();
        logic [1:0] tags [5];
        int k, cyc, got, last;
        logic need_new;
        tags = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_q.delete();
        bus.rsp_ready = 1'b0;
        k = 0; cyc = 0; need_new = 1'b1;
        @(posedge clk); #1;
        while (k < 5 && cyc < 50) begin
            if (need_new) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
                bus.cmd_op = 3'($urandom_range(0, 4)); bus.cmd_tag = tags[k];
                need_new = 1'b0;
            end
            @(negedge clk);
            if (bus.cmd_ready) begin
                exp_q.push_back(ref_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag));
                k++;
                need_new = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        n_checks++;
        if (k !== 5) begin n_fail++; $display("FAIL fill_accept_count: got %0d want 5", k); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_tag} !== {3'b011, 2'd0}) begin
            n_fail++; $display("FAIL fill_full ready/busy/valid/tag: got %b%b%b %0d want 011 0",
                               bus.cmd_ready, busy, bus.rsp_valid, bus.rsp_tag);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        got = 0; last = -1; cyc = 0;
        while (got < 5 && cyc < 40) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL fill_extra_rsp: got %h want none", obs_rsp());
                end else if (obs_rsp() !== exp_q[0]) begin
                    n_fail++; $display("FAIL fill_rsp%0d: got %h want %h", got, obs_rsp(), exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                n_checks++;
                if (bus.rsp_tag !== tags[got]) begin n_fail++; $display("FAIL fill_tag%0d: got %0d want %0d", got, bus.rsp_tag, tags[got]); end
                if (got > 0) begin
                    n_checks++;
                    if (cyc - last != 2) begin n_fail++; $display("FAIL fill_spacing%0d: got %0d want 2", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (got !== 5) begin n_fail++; $display("FAIL fill_rsp_count: got %0d want 5", got); end
    endtask

    // 100 random commands (all opcodes) with random response back-pressure.
    task automatic test_random_stall();
        int sent, got, cyc;
        logic pending, stall_prev;
        logic [W-1:0] snap, obs;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; pending = 1'b0; stall_prev = 1'b0; snap = '0;
        @(posedge clk); #1;
        while (got < 100 && cyc < 3000) begin
            if (!pending && sent < 100 && $urandom_range(0, 3) != 0) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
                bus.cmd_op = 3'($urandom_range(0, 7)); bus.cmd_tag = 2'($urandom_range(0, 3));
                pending = 1'b1;
            end else if (!pending) begin
                bus.cmd_valid = 1'b0;
            end
            bus.rsp_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            obs = obs_rsp();
            if (stall_prev) begin
                n_checks++;
                if ({bus.rsp_valid, obs} !== {1'b1, snap}) begin
                    n_fail++; $display("FAIL rand_stall_stable: got %b %h want 1 %h", bus.rsp_valid, obs, snap);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra_rsp: got %h want none", obs);
                end else begin
                    if (obs !== exp_q[0]) begin n_fail++; $display("FAIL rand_rsp%0d: got %h want %h", got, obs, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                exp_q.push_back(ref_rsp(bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag));
                sent++;
                pending = 1'b0;
            end
            stall_prev = bus.rsp_valid && !bus.rsp_ready;
            snap = obs;
            @(posedge clk); #1;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        n_checks++;
        if (got !== 100 || sent !== 100 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_counts: got rsp=%0d sent=%0d left=%0d want 100 100 0", got, sent, exp_q.size());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_drain_busy: got %b want 0", busy); end
    endtask

    // Reset while a response is stalled and two commands are queued.
    task automatic test_reset_mid_resp();
        int k, cyc, seen;
        bus.rsp_ready = 1'b0;
        k = 0; cyc = 0;
        @(posedge clk); #1;
        while (k < 3 && cyc < 30) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a = 8'($urandom); bus.cmd_b = 8'($urandom);
            bus.cmd_op = 3'($urandom_range(0, 4)); bus.cmd_tag = 2'(k);
            @(negedge clk);
            if (bus.cmd_ready) k++;
            @(posedge clk); #1;
            cyc++;
        end
        bus.cmd_valid = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (!bus.rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if ({bus.rsp_valid, state} !== {1'b1, ST_RESP}) begin
            n_fail++; $display("FAIL rstmid_in_resp valid/state: got %b %0d want 1 %0d", bus.rsp_valid, state, ST_RESP);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, busy, bus.cmd_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_after valid/busy/ready: got %b%b%b want 001", bus.rsp_valid, busy, bus.cmd_ready);
        end
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid || busy) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_further_rsp: got %0d active cycles want 0", seen); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_fill_order();
        test_random_stall();
        test_reset_mid_resp();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
